// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, load/store and SRAM master signals shared by mem_bus_arbiter.
// slave = arbiter side, master = core front-end / LSU / AXI master side.
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [1:0]  if_size;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        ls_req;
  logic        ls_wen;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_ack;
  logic        mst_en;
  logic        mst_wen;
  logic [31:0] mst_addr;
  logic [1:0]  mst_size;
  logic [31:0] mst_din;
  logic [31:0] mst_dout;
  logic        mst_done;
  logic        busy;

  modport slave (
    input  if_req, if_addr, if_size, ls_req, ls_wen, ls_addr, ls_size, ls_wdata,
           mst_dout, mst_done,
    output if_rdata, if_ack, ls_rdata, ls_ack, mst_en, mst_wen, mst_addr, mst_size,
           mst_din, busy
  );

  modport master (
    output if_req, if_addr, if_size, ls_req, ls_wen, ls_addr, ls_size, ls_wdata,
           mst_dout, mst_done,
    input  if_rdata, if_ack, ls_rdata, ls_ack, mst_en, mst_wen, mst_addr, mst_size,
           mst_din, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch, load/store) arbiter in front of the single SRAM master port.
// Default: fixed ls priority with if starvation guard; define MEM_ARB_RR_EN for round-robin.
module mem_bus_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int STARVE_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_owner_ls, w_owner_ls_nxt;
  logic        r_mst_en, w_mst_en_nxt;
  logic        r_mst_wen, w_mst_wen_nxt;
  logic [31:0] r_mst_addr, w_mst_addr_nxt;
  logic [1:0]  r_mst_size, w_mst_size_nxt;
  logic [31:0] r_mst_din, w_mst_din_nxt;
  logic        r_if_ack, w_if_ack_nxt;
  logic        r_ls_ack, w_ls_ack_nxt;
  logic [31:0] r_if_rdata, w_if_rdata_nxt;
  logic [31:0] r_ls_rdata, w_ls_rdata_nxt;
  logic        w_any_req;
  logic        w_pick_ls;

  assign w_any_req = bus.if_req | bus.ls_req;

`ifdef MEM_ARB_RR_EN
  // On conflict the requester that did not own the last transaction wins.
  assign w_pick_ls = bus.ls_req & ~(bus.if_req & r_owner_ls);
`else
  logic [STARVE_W-1:0] r_starve_cnt, w_starve_nxt;
  logic                w_force_if;

  assign w_force_if = bus.if_req & (r_starve_cnt == STARVE_W'(STARVE_MAX));
  assign w_pick_ls  = bus.ls_req & ~w_force_if;

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (r_state == S_IDLE) begin
      if (!bus.if_req)
        w_starve_nxt = '0;
      else if (w_pick_ls) begin
        if (r_starve_cnt != STARVE_W'(STARVE_MAX))
          w_starve_nxt = r_starve_cnt + STARVE_W'(1);
      end else
        w_starve_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_starve_cnt <= '0;
    else     r_starve_cnt <= w_starve_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner_ls <= 1'b0;
      r_mst_en   <= 1'b0;
      r_mst_wen  <= 1'b0;
      r_mst_addr <= '0;
      r_mst_size <= '0;
      r_mst_din  <= '0;
      r_if_ack   <= 1'b0;
      r_ls_ack   <= 1'b0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner_ls <= w_owner_ls_nxt;
      r_mst_en   <= w_mst_en_nxt;
      r_mst_wen  <= w_mst_wen_nxt;
      r_mst_addr <= w_mst_addr_nxt;
      r_mst_size <= w_mst_size_nxt;
      r_mst_din  <= w_mst_din_nxt;
      r_if_ack   <= w_if_ack_nxt;
      r_ls_ack   <= w_ls_ack_nxt;
      r_if_rdata <= w_if_rdata_nxt;
      r_ls_rdata <= w_ls_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any_req) w_state_nxt = S_GRANT;
      S_GRANT:   if (bus.mst_done) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_owner_ls_nxt = r_owner_ls;
    w_mst_en_nxt   = r_mst_en;
    w_mst_wen_nxt  = r_mst_wen;
    w_mst_addr_nxt = r_mst_addr;
    w_mst_size_nxt = r_mst_size;
    w_mst_din_nxt  = r_mst_din;
    w_if_ack_nxt   = 1'b0;
    w_ls_ack_nxt   = 1'b0;
    w_if_rdata_nxt = r_if_rdata;
    w_ls_rdata_nxt = r_ls_rdata;
    case (r_state)
      S_IDLE: begin
        w_mst_en_nxt = w_any_req;
        if (w_any_req) begin
          w_owner_ls_nxt = w_pick_ls;
          if (w_pick_ls) begin
            w_mst_wen_nxt  = bus.ls_wen;
            w_mst_addr_nxt = bus.ls_addr;
            w_mst_size_nxt = bus.ls_size;
            w_mst_din_nxt  = bus.ls_wdata;
          end else begin
            w_mst_wen_nxt  = 1'b0;
            w_mst_addr_nxt = bus.if_addr;
            w_mst_size_nxt = bus.if_size;
            w_mst_din_nxt  = '0;
          end
        end
      end
      S_GRANT: begin
        // Writes complete without touching the owner's read data.
        if (bus.mst_done) begin
          w_mst_en_nxt = 1'b0;
          if (r_owner_ls) begin
            w_ls_ack_nxt = 1'b1;
            if (!r_mst_wen) w_ls_rdata_nxt = bus.mst_dout;
          end else begin
            w_if_ack_nxt   = 1'b1;
            w_if_rdata_nxt = bus.mst_dout;
          end
        end
      end
      S_RELEASE: w_mst_en_nxt = 1'b0;
      default:   w_mst_en_nxt = 1'b0;
    endcase
  end

  assign bus.mst_en   = r_mst_en;
  assign bus.mst_wen  = r_mst_wen;
  assign bus.mst_addr = r_mst_addr;
  assign bus.mst_size = r_mst_size;
  assign bus.mst_din  = r_mst_din;
  assign bus.if_ack   = r_if_ack;
  assign bus.ls_ack   = r_ls_ack;
  assign bus.if_rdata = r_if_rdata;
  assign bus.ls_rdata = r_ls_rdata;
  assign bus.busy     = (r_state != S_IDLE);

endmodule
